mem_port_arbiter: RTL

- Parametrised two-master to one-port memory arbiter with a handshake.
- Lets the instruction-fetch path and the load/store path of a core share a single memory port.
- Target memory may take variable wait states; it signals completion on an accessable strobe.
- Sits between the core's instruction and data buses and the shared memory; adds priority/round-robin arbitration, byte enables and a timeout abort.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: instruction, data and shared-memory signals of the two-master memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      inst_req;
    logic [ADDR_WIDTH-1:0]     inst_addr;
    logic [DATA_WIDTH-1:0]     inst_rdata;
    logic                      inst_ready;
    logic                      data_rd;
    logic                      data_wr;
    logic [ADDR_WIDTH-1:0]     data_addr;
    logic [DATA_WIDTH-1:0]     data_wdata;
    logic [DATA_WIDTH/8-1:0]   data_be;
    logic [DATA_WIDTH-1:0]     data_rdata;
    logic                      data_ready;
    logic                      err;
    logic                      mem_rd;
    logic                      mem_wr;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_be;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic                      mem_accessable;
    modport slave (
        input  inst_req, inst_addr, data_rd, data_wr, data_addr, data_wdata, data_be,
               mem_rdata, mem_accessable,
        output inst_rdata, inst_ready, data_rdata, data_ready, err,
               mem_rd, mem_wr, mem_addr, mem_wdata, mem_be
    );
    modport master (
        output inst_req, inst_addr, data_rd, data_wr, data_addr, data_wdata, data_be,
               mem_rdata, mem_accessable,
        input  inst_rdata, inst_ready, data_rdata, data_ready, err,
               mem_rd, mem_wr, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one wait-stated memory port between instruction fetch and load/store,
// with data-priority or round-robin tie breaking and a timeout abort.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15,
    parameter bit DATA_PRIO  = 1'b1
) (
    input logic clk,
    input logic rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
    state_t                state, state_n;
    logic                  gnt_data, gnt_data_n, rr_data, rr_data_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  rd_q, rd_n, wr_q, wr_n;
    logic                  iready_q, iready_n, dready_q, dready_n, err_q, err_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n, rdata_q, rdata_n;
    logic [BW-1:0]         be_q, be_n;
    logic                  dreq, pick_data, is_wr, timed_out;
    always_comb begin
        dreq       = bus.data_rd | bus.data_wr;
        // rr_data set means the data side is owed the next tie
        pick_data  = dreq & (~bus.inst_req | DATA_PRIO | rr_data);
        is_wr      = pick_data & bus.data_wr;
        timed_out  = TIMEOUT > 0 && cnt == CW'(TIMEOUT - 1);
        state_n    = state;
        gnt_data_n = gnt_data;
        rr_data_n  = rr_data;
        cnt_n      = cnt;
        rd_n       = rd_q;
        wr_n       = wr_q;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        be_n       = be_q;
        rdata_n    = rdata_q;
        iready_n   = 1'b0;
        dready_n   = 1'b0;
        err_n      = 1'b0;
        case (state)
            IDLE: if (dreq | bus.inst_req) begin
                state_n    = ACC;
                gnt_data_n = pick_data;
                rr_data_n  = ~pick_data;
                cnt_n      = '0;
                rd_n       = ~is_wr;
                wr_n       = is_wr;
                addr_n     = pick_data ? bus.data_addr : bus.inst_addr;
                wdata_n    = is_wr ? bus.data_wdata : '0;
                be_n       = is_wr ? bus.data_be : '1;
            end
            ACC: begin
                cnt_n = cnt + CW'(1);
                if (bus.mem_accessable || timed_out) begin
                    state_n  = RESP;
                    rd_n     = 1'b0;
                    wr_n     = 1'b0;
                    rdata_n  = (bus.mem_accessable && rd_q) ? bus.mem_rdata : '0;
                    err_n    = ~bus.mem_accessable;
                    iready_n = ~gnt_data;
                    dready_n = gnt_data;
                end
            end
            RESP: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_data <= 1'b0;
            rr_data  <= 1'b0;
            cnt      <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
            iready_q <= 1'b0;
            dready_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            gnt_data <= gnt_data_n;
            rr_data  <= rr_data_n;
            cnt      <= cnt_n;
            rd_q     <= rd_n;
            wr_q     <= wr_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            be_q     <= be_n;
            rdata_q  <= rdata_n;
            iready_q <= iready_n;
            dready_q <= dready_n;
            err_q    <= err_n;
        end
    end
    assign bus.mem_rd     = rd_q;
    assign bus.mem_wr     = wr_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_be     = be_q;
    assign bus.inst_rdata = rdata_q;
    assign bus.data_rdata = rdata_q;
    assign bus.inst_ready = iready_q;
    assign bus.data_ready = dready_q;
    assign bus.err        = err_q;
endmodule
